// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a skid register: in_ready_o is a pure function of
// the held-entry count, so upstream never sees a combinational path from out_ready_i.
module pipe_stage_skid #(
    parameter int                  DATA_W  = 32,
    parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        count_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_reg;
    logic [DATA_W-1:0] skid_next;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // State and payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            main_reg  <= RST_VAL;
            skid_reg  <= RST_VAL;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    // Next-state and payload steering
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush_i) begin
            // A delivery in this cycle has already happened; everything still held is dropped.
            state_next = ST_EMPTY;
            main_next  = RST_VAL;
            skid_next  = RST_VAL;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_ONE;
                        main_next  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next = ST_TWO;
                        skid_next  = in_data_i;
                    end else if (in_fire && out_fire) begin
                        main_next  = in_data_i;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                        main_next  = RST_VAL;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_next = ST_ONE;
                        main_next  = skid_reg;
                        skid_next  = RST_VAL;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_next  = RST_VAL;
                    skid_next  = RST_VAL;
                end
            endcase
        end
    end

    // Outputs decode from state only
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        count_o     = 2'd0;
        out_data_o  = RST_VAL;
        case (state_reg)
            ST_EMPTY: begin
                in_ready_o = 1'b1;
            end
            ST_ONE: begin
                in_ready_o  = 1'b1;
                out_valid_o = 1'b1;
                count_o     = 2'd1;
                out_data_o  = main_reg;
            end
            ST_TWO: begin
                out_valid_o = 1'b1;
                count_o     = 2'd2;
                out_data_o  = main_reg;
            end
            default: begin
                in_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives an 8-bit and a 200-bit instance in lockstep and compares both against a
// queue model of a two-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam logic [7:0]   RST8   = 8'h5A;
    localparam logic [199:0] RST200 = {25{8'h3C}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data8 = '0;
    logic [199:0] in_data200 = '0;
    logic         out_ready = 1'b0;

    logic         in_ready8, out_valid8;
    logic [7:0]   out_data8;
    logic [1:0]   count8;
    logic         in_ready200, out_valid200;
    logic [199:0] out_data200;
    logic [1:0]   count200;

    int checks = 0;
    int errors = 0;

    logic [199:0] model_q[$];
    bit           armed = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(8), .RST_VAL(RST8)) dut8 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_data_i(in_data8), .in_ready_o(in_ready8),
        .out_valid_o(out_valid8), .out_data_o(out_data8), .out_ready_i(out_ready),
        .count_o(count8)
    );

    pipe_stage_skid #(.DATA_W(200), .RST_VAL(RST200)) dut200 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_data_i(in_data200), .in_ready_o(in_ready200),
        .out_valid_o(out_valid200), .out_data_o(out_data200), .out_ready_i(out_ready),
        .count_o(count200)
    );

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model's current contents
    task automatic check_model();
        int n;
        n = model_q.size();
        chk("count8",     200'(count8),      200'(n));
        chk("count200",   200'(count200),    200'(n));
        chk("valid8",     200'(out_valid8),  200'(n > 0));
        chk("valid200",   200'(out_valid200),200'(n > 0));
        chk("ready8",     200'(in_ready8),   200'(n < 2));
        chk("ready200",   200'(in_ready200), 200'(n < 2));
        if (n > 0) begin
            chk("data8",   200'(out_data8), 200'(model_q[0][7:0]));
            chk("data200", out_data200,     model_q[0]);
        end else begin
            chk("data8_empty",   200'(out_data8), 200'(RST8));
            chk("data200_empty", out_data200,     RST200);
        end
    endtask

    // One clock cycle: drive, check, probe for combinational ready paths, advance model
    task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit f, input bit rs);
        bit ifire, ofire;
        bit exp_ready;
        @(negedge clk);
        in_valid   = v;
        in_data8   = d;
        in_data200 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, d};
        out_ready  = r;
        flush      = f;
        rst        = rs;
        #1;
        if (armed) begin
            check_model();
            exp_ready = (model_q.size() < 2);
            out_ready = ~r;
            in_valid  = ~v;
            #1;
            chk("ready_no_comb_path", 200'(in_ready8), 200'(exp_ready));
            out_ready = r;
            in_valid  = v;
            #1;
        end
        ifire = v && (model_q.size() < 2);
        ofire = r && (model_q.size() > 0);
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            armed = 1'b1;
        end else begin
            if (ofire) void'(model_q.pop_front());
            if (f) model_q.delete();
            else if (ifire) model_q.push_back(in_data200);
        end
        $display("cycle t=%0t v=%0b d=%h r=%0b f=%0b rst=%0b held=%0d", $time, v, d, r, f, rs, model_q.size());
    endtask

    // Directed expectation of the 8-bit instance just after an edge
    task automatic peek(input string tag, input bit ev, input logic [7:0] ed, input int ec);
        #2;
        chk({tag, "_valid"}, 200'(out_valid8), 200'(ev));
        chk({tag, "_data"},  200'(out_data8),  200'(ed));
        chk({tag, "_count"}, 200'(count8),     200'(ec));
        chk({tag, "_ready"}, 200'(in_ready8),  200'(ec < 2));
    endtask

    initial begin
        // Reset
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        peek("reset", 0, RST8, 0);

        // Pass-through
        cycle(1, 8'h11, 1, 0, 0); peek("pt1", 1, 8'h11, 1);
        cycle(1, 8'h22, 1, 0, 0); peek("pt2", 1, 8'h22, 1);
        cycle(1, 8'h33, 1, 0, 0); peek("pt3", 1, 8'h33, 1);
        cycle(0, 8'h00, 1, 0, 0); peek("pt_drain", 0, RST8, 0);

        // Backpressure
        cycle(1, 8'hA1, 0, 0, 0); peek("bp1", 1, 8'hA1, 1);
        cycle(1, 8'hA2, 0, 0, 0); peek("bp2", 1, 8'hA1, 2);
        cycle(1, 8'hA3, 0, 0, 0); peek("bp3_held", 1, 8'hA1, 2);
        cycle(1, 8'hA3, 1, 0, 0); peek("bp_out1", 1, 8'hA2, 1);
        cycle(1, 8'hA3, 1, 0, 0); peek("bp_out2", 1, 8'hA3, 1);
        cycle(0, 8'h00, 1, 0, 0); peek("bp_drain", 0, RST8, 0);

        // Flush while full with a simultaneous offer
        cycle(1, 8'hB1, 0, 0, 0);
        cycle(1, 8'hB2, 0, 0, 0); peek("fl_full", 1, 8'hB1, 2);
        cycle(1, 8'hB3, 0, 1, 0); peek("fl_kill", 0, RST8, 0);
        cycle(0, 8'h00, 1, 0, 0); peek("fl_after", 0, RST8, 0);

        // Simultaneous accept and deliver in ONE
        cycle(1, 8'hC1, 0, 0, 0); peek("sim_hold", 1, 8'hC1, 1);
        cycle(1, 8'hC2, 1, 0, 0); peek("sim_swap", 1, 8'hC2, 1);
        cycle(0, 8'h00, 1, 0, 0); peek("sim_drain", 0, RST8, 0);

        // Reset while full
        cycle(1, 8'hE1, 0, 0, 0);
        cycle(1, 8'hE2, 0, 0, 0); peek("mr_full", 1, 8'hE1, 2);
        cycle(1, 8'hE3, 1, 0, 1); peek("mr_reset", 0, RST8, 0);
        cycle(1, 8'hD1, 1, 0, 0); peek("mr_d1", 1, 8'hD1, 1);
        cycle(0, 8'h00, 1, 0, 0);

        // Random traffic, both widths against the queue model
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  8'($urandom),
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) < 2);
        end
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the payload bus (the concatenated stage fields: instruction, address, write-back data/enable/address, ALU result, memory indices, rs2 data).
REQ-002 The block SHALL have parameter RST_VAL, default 0, which is the payload value presented while the stage holds no valid entry (bubble/NOP encoding).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush_i  input  1  discard all held entries this cycle (branch/exception kill).
REQ-006 in_valid_i  input  1  upstream offers in_data_i.
REQ-007 in_data_i  input  DATA_W  upstream payload.
REQ-008 in_ready_o  output  1  stage can accept a payload this cycle.
REQ-009 out_valid_o  output  1  out_data_o holds a valid payload.
REQ-010 out_data_o  output  DATA_W  downstream payload.
REQ-011 out_ready_i  input  1  downstream accepts out_data_o this cycle.
REQ-012 count_o  output  2  number of held entries, 0..2.

Function
REQ-013 in_fire SHALL be in_valid_i AND in_ready_o; out_fire SHALL be out_valid_o AND out_ready_i.
REQ-014 Storage SHALL be one main register (drives out_data_o) and one skid register; state SHALL be EMPTY, ONE or TWO, with count_o = 0/1/2 respectively.
REQ-015 in_ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO, and SHALL depend only on state (no combinational path from out_ready_i or in_valid_i).
REQ-016 out_valid_o SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-017 out_data_o SHALL equal RST_VAL whenever state is EMPTY.
REQ-018 EMPTY: in_fire -> ONE, main <= in_data_i; otherwise stay EMPTY.
REQ-019 ONE: in_fire & !out_fire -> TWO, skid <= in_data_i; in_fire & out_fire -> ONE, main <= in_data_i; !in_fire & out_fire -> EMPTY; neither -> hold ONE, main unchanged.
REQ-020 TWO: out_fire -> ONE, main <= skid; otherwise hold TWO, both registers unchanged.
REQ-021 Latency SHALL be exactly 1 cycle from in_fire to that payload appearing on out_data_o with out_valid_o = 1 when the stage was EMPTY, or ONE with simultaneous out_fire.
REQ-022 With out_ready_i held 1, sustained throughput SHALL be one payload per cycle with no bubbles.
REQ-023 Payload order SHALL be strictly FIFO; no payload is duplicated or dropped except by flush_i or rst.
REQ-024 While out_valid_o = 1 and out_fire = 0, out_data_o SHALL remain stable.
REQ-025 flush_i = 1 SHALL force next state EMPTY, discarding main, skid and any simultaneous in_fire payload; out_fire occurring in the flush cycle still counts as delivered.
REQ-026 rst SHALL take priority over flush_i and all handshakes.

Reset
REQ-027 On a clock edge with rst = 1: state <= EMPTY, main <= RST_VAL, skid <= RST_VAL.
REQ-028 In the cycle after reset: out_valid_o = 0, out_data_o = RST_VAL, in_ready_o = 1, count_o = 0.
REQ-029 Reset asserted mid-operation (state ONE or TWO) SHALL discard all held payloads identically to REQ-027.

Verification
REQ-030 Pass-through: out_ready_i = 1, drive 0x11,0x22,0x33 on consecutive cycles -> out_data_o shows 0x11,0x22,0x33 on the following three cycles, count_o = 1 throughout, in_ready_o = 1.
REQ-031 Backpressure: out_ready_i = 0, drive 0xA1,0xA2,0xA3 -> count_o goes 1,2; in_ready_o = 0 after second accept; 0xA3 held upstream; raise out_ready_i -> outputs 0xA1,0xA2,0xA3 in order, none lost.
REQ-032 Flush in TWO: fill with 0xB1,0xB2, assert flush_i with in_valid_i = 1 (0xB3) -> next cycle out_valid_o = 0, out_data_o = RST_VAL, count_o = 0; 0xB3 never appears.
REQ-033 Simultaneous in/out in ONE: held 0xC1, in 0xC2 with out_ready_i = 1 -> 0xC1 delivered, next cycle out_data_o = 0xC2, count_o = 1.
REQ-034 Reset mid-operation: state TWO, assert rst for one cycle -> outputs equal REQ-028 values; subsequent 0xD1 passes with 1-cycle latency.
REQ-035 Random valid/ready with DATA_W = 8 and DATA_W = 200 -> scoreboard shows FIFO order, no loss/duplication, in_ready_o never depends combinationally on out_ready_i.
